// File: rtl/osfm_column_reducer.sv
// Three-stage carry-save column reducer for the OSFM partial-product array, with valid/ready back-pressure.
// Define OSFM_TRUNC_EN to output only the upper BITWIDTH bits of the reduced sum.
module osfm_column_reducer #(
    parameter int BITWIDTH = 8,
    parameter int COLS     = 2*BITWIDTH,
    parameter int HEIGHT   = BITWIDTH/2+2,
`ifdef OSFM_TRUNC_EN
    localparam int OUT_W   = BITWIDTH
`else
    localparam int OUT_W   = 2*BITWIDTH
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COLS*HEIGHT-1:0]   pp_cols,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_product
);
    localparam int PW = 2*BITWIDTH;

    logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [COLS*HEIGHT-1:0] pp_q, pp_d;
    logic [PW-1:0]          sum_q, sum_d, carry_q, carry_d;
    logic [OUT_W-1:0]       prod_q, prod_d;
    logic                   ready3, ready2, adv2, adv1;
    logic [PW-1:0]          red_sum, red_carry;
    logic [OUT_W-1:0]       add_res;

    // Each stage accepts when empty or when its successor drains this cycle.
    always_comb begin
        ready3   = !v3_q || out_ready;
        adv2     = v2_q && ready3;
        ready2   = !v2_q || adv2;
        adv1     = v1_q && ready2;
        in_ready = !v1_q || adv1;

        v1_d     = in_ready ? in_valid : v1_q;
        v2_d     = ready2 ? v1_q : v2_q;
        v3_d     = ready3 ? v2_q : v3_q;
        pp_d     = (in_valid && in_ready) ? pp_cols : pp_q;
        sum_d    = adv1 ? red_sum : sum_q;
        carry_d  = adv1 ? red_carry : carry_q;
        prod_d   = adv2 ? add_res : prod_q;
    end

    // Rows are bit-slices across columns; a chain of 3:2 counters folds each new row into the sum/carry pair.
    always_comb begin
        logic [PW-1:0] row_k;
        logic [PW-1:0] s_acc;
        logic [PW-1:0] c_acc;
        logic [PW-1:0] s_nxt;
        row_k = '0;
        s_acc = '0;
        c_acc = '0;
        s_nxt = '0;
        for (int k = 0; k < HEIGHT; k++) begin
            row_k = '0;
            for (int c = 0; c < PW; c++) begin
                if (c < COLS) begin
                    row_k[c] = pp_q[c*HEIGHT+k];
                end
            end
            if (k == 0) begin
                s_acc = row_k;
            end else if (k == 1) begin
                c_acc = row_k;
            end else begin
                s_nxt = s_acc ^ c_acc ^ row_k;
                c_acc = ((s_acc & c_acc) | (s_acc & row_k) | (c_acc & row_k)) << 1;
                s_acc = s_nxt;
            end
        end
        red_sum   = s_acc;
        red_carry = c_acc;
    end

`ifdef OSFM_TRUNC_EN
    // Only the carry out of the lower half is kept; its sum bits are never needed.
    logic [BITWIDTH:0] lo_sum;
    always_comb begin
        lo_sum  = {1'b0, sum_q[BITWIDTH-1:0]} + {1'b0, carry_q[BITWIDTH-1:0]};
        add_res = sum_q[PW-1:BITWIDTH] + carry_q[PW-1:BITWIDTH]
                + {{(BITWIDTH-1){1'b0}}, lo_sum[BITWIDTH]};
    end
`else
    always_comb begin
        add_res = sum_q + carry_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            pp_q    <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            prod_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            pp_q    <= pp_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            prod_q  <= prod_d;
        end
    end

    assign out_valid   = v3_q;
    assign out_product = prod_q;
endmodule

// File: tb/tb_osfm_column_reducer.sv
// Directed and random bench for osfm_column_reducer with a queue-based scoreboard.
// Define OSFM_TRUNC_EN to check the truncated build.
module tb_osfm_column_reducer;
    localparam int N    = 8;
    localparam int COLS = 2*N;
    localparam int H    = N/2+2;
    localparam int W    = COLS*H;
`ifdef OSFM_TRUNC_EN
    localparam int OW   = N;
`else
    localparam int OW   = 2*N;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  pp_cols;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_product;

    osfm_column_reducer #(.BITWIDTH(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pp_cols(pp_cols), .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product)
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    int            passed = 0;
    int            total = 0;
    int            n_xfer = 0;
    int            last_lat = 0;
    bit            lat_check = 1'b0;
    logic [OW-1:0] exp_q[$];
    int            acc_q[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [OW-1:0] tr(input logic [15:0] full);
`ifdef OSFM_TRUNC_EN
        return full[15:8];
`else
        return full;
`endif
    endfunction

    function automatic logic [OW-1:0] golden(input logic [W-1:0] pp);
        logic [31:0] acc;
        acc = 0;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < H; k++)
                if (pp[c*H+k]) acc = acc + (32'd1 << c);
        return tr(acc[15:0]);
    endfunction

    function automatic logic [W-1:0] col0(input int n);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Output transfer happens at the edge following a negedge with out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [OW-1:0] e;
            int            a;
            n_xfer++;
            check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                last_lat = cyc + 1 - a;
                check("product", 32'(out_product), 32'(e));
                if (lat_check) check("latency", last_lat, 32'd3);
                $display("xfer %0d: product=%0h expected=%0h latency=%0d", n_xfer, out_product, e, last_lat);
            end
        end
    end

    task automatic send(input logic [W-1:0] pp, input logic [OW-1:0] e, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        pp_cols = pp;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc + 1);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        pp_cols = {$urandom, $urandom, $urandom};
        if (!done) check("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int            st;
        int            st_sum;
        int            n0;
        logic [W-1:0]  pp;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        pp_cols = '0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_product", 32'(out_product), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Directed corner patterns, each checked with 3-edge latency.
        out_ready = 1'b1;
        lat_check = 1'b1;
        send(col0(6), tr(16'h0006), st);
        drain();
        send({W{1'b1}}, tr(16'hFFFA), st);
        drain();
        pp = '0; pp[15*H] = 1'b1;
        send(pp, tr(16'h8000), st);
        drain();
        pp = '0; pp[15*H] = 1'b1; pp[15*H+1] = 1'b1;
        send(pp, tr(16'h0000), st);
        drain();

        // Back-to-back random stream.
        st_sum = 0;
        n0 = n_xfer;
        for (int i = 0; i < 20; i++) begin
            pp = {$urandom, $urandom, $urandom};
            send(pp, golden(pp), st);
            st_sum += st;
        end
        check("stream_stalls", st_sum, 32'd0);
        drain();
        check("stream_count", n_xfer - n0, 32'd20);

        // Back-pressure: three fill the pipe, fourth waits for out_ready.
        lat_check = 1'b0;
        out_ready = 1'b0;
        st_sum = 0;
        for (int v = 1; v <= 3; v++) begin
            send(col0(v), tr(16'(v)), st);
            st_sum += st;
        end
        check("fill_stalls", st_sum, 32'd0);
        in_valid = 1'b1;
        pp_cols = col0(5);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_hold_in_ready", 32'(in_ready), 32'd0);
        check("full_hold_product", 32'(out_product), 32'(tr(16'd1)));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(col0(4), tr(16'd4), st);
        check("fourth_same_cycle", st, 32'd0);
        drain();

        // Reset with two transactions in flight.
        send(col0(3), tr(16'd3), st);
        send(col0(2), tr(16'd2), st);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        acc_q.delete();
        n0 = n_xfer;
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat_check = 1'b1;
        send(col0(5), tr(16'd5), st);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_count", n_xfer - n0, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
